// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: address width,
// the x0 constant, the source encoding and the default queued-entry layout.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;
  localparam int WB_DATA_W = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending register writes from one producer.
// Exposes every slot's valid bit and address so the owner can answer pending-write queries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = wb_entry_t,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  entry_t                             push_entry,
  input  logic                               pop,
  output logic                               head_valid,
  output entry_t                             head_entry,
  output logic                               full,
  output logic [PW:0]                        count,
  output logic [DEPTH-1:0]                   ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_addr
);
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   cnt_r;

  // Storage, pointers and occupancy; caller guarantees push only when not full, pop only when non-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_r] <= push_entry;
        wr_ptr_r      <= wr_ptr_r + PW'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head_valid = (cnt_r != '0);
  assign head_entry = mem[rd_ptr_r];
  assign full       = (cnt_r == (PW+1)'(DEPTH));
  assign count      = cnt_r;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(i) - rd_ptr_r} < cnt_r);
      ent_addr[i]  = mem[i].addr;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues ALU and LSU results, round-robins them onto the
// single register-file write port, and answers bypass / pending-write queries.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd_addr,
  input  logic [DATA_WIDTH-1:0]  alu_rd_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [4:0]             lsu_rd_addr,
  input  logic [DATA_WIDTH-1:0]  lsu_rd_data,
  output logic                   rd_we,
  output logic [4:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  output logic                   rs1_fwd_hit,
  output logic                   rs2_fwd_hit,
  output logic [DATA_WIDTH-1:0]  fwd_data,
  output logic                   rs1_pending,
  output logic                   rs2_pending,
  output logic [3:0]             pending_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                                alu_head_s, lsu_head_s, gnt_entry_s;
  logic                                  alu_head_v_s, lsu_head_v_s;
  logic                                  alu_full_s, lsu_full_s;
  logic [CW-1:0]                         alu_cnt_s, lsu_cnt_s;
  logic [FIFO_DEPTH-1:0]                 alu_ent_v_s, lsu_ent_v_s;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] alu_ent_a_s, lsu_ent_a_s;
  logic                                  gnt_v_s, alu_pop_s, lsu_pop_s;
  logic                                  rs1_match_s, rs2_match_s;
  src_e                                  gnt_src_s, last_grant_r;

  assign alu_ready = !alu_full_s;
  assign lsu_ready = !lsu_full_s;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_alu_fifo (
    .clk(clk), .rst(rst),
    .push(alu_valid && alu_ready), .push_entry('{addr: alu_rd_addr, data: alu_rd_data}),
    .pop(alu_pop_s), .head_valid(alu_head_v_s), .head_entry(alu_head_s),
    .full(alu_full_s), .count(alu_cnt_s), .ent_valid(alu_ent_v_s), .ent_addr(alu_ent_a_s)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_lsu_fifo (
    .clk(clk), .rst(rst),
    .push(lsu_valid && lsu_ready), .push_entry('{addr: lsu_rd_addr, data: lsu_rd_data}),
    .pop(lsu_pop_s), .head_valid(lsu_head_v_s), .head_entry(lsu_head_s),
    .full(lsu_full_s), .count(lsu_cnt_s), .ent_valid(lsu_ent_v_s), .ent_addr(lsu_ent_a_s)
  );

  // Round-robin grant: on a conflict the source that did not win last time goes first.
  always_comb begin
    gnt_v_s   = 1'b0;
    gnt_src_s = SRC_ALU;
    if (alu_head_v_s && lsu_head_v_s) begin
      gnt_v_s   = 1'b1;
      gnt_src_s = (last_grant_r == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end else if (alu_head_v_s) begin
      gnt_v_s   = 1'b1;
      gnt_src_s = SRC_ALU;
    end else if (lsu_head_v_s) begin
      gnt_v_s   = 1'b1;
      gnt_src_s = SRC_LSU;
    end else begin
      gnt_v_s   = 1'b0;
      gnt_src_s = SRC_ALU;
    end
  end

  assign alu_pop_s   = gnt_v_s && (gnt_src_s == SRC_ALU);
  assign lsu_pop_s   = gnt_v_s && (gnt_src_s == SRC_LSU);
  assign gnt_entry_s = (gnt_src_s == SRC_ALU) ? alu_head_s : lsu_head_s;

  // Output register; an x0 entry still takes its slot but never raises the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_we        <= 1'b0;
      rd_addr      <= 5'd0;
      rd_data      <= '0;
      last_grant_r <= SRC_LSU;
    end else if (gnt_v_s) begin
      rd_we        <= (gnt_entry_s.addr != REG_X0);
      rd_addr      <= gnt_entry_s.addr;
      rd_data      <= gnt_entry_s.data;
      last_grant_r <= gnt_src_s;
    end else begin
      rd_we        <= 1'b0;
    end
  end

  assign rs1_fwd_hit = rd_we && (rd_addr == rs1_addr);
  assign rs2_fwd_hit = rd_we && (rd_addr == rs2_addr);
  assign fwd_data    = rd_data;

  // Pending scan over every live queued entry; the issued entry has already left its FIFO.
  always_comb begin
    rs1_match_s = 1'b0;
    rs2_match_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      rs1_match_s = rs1_match_s | (alu_ent_v_s[i] && (alu_ent_a_s[i] == rs1_addr))
                                | (lsu_ent_v_s[i] && (lsu_ent_a_s[i] == rs1_addr));
      rs2_match_s = rs2_match_s | (alu_ent_v_s[i] && (alu_ent_a_s[i] == rs2_addr))
                                | (lsu_ent_v_s[i] && (lsu_ent_a_s[i] == rs2_addr));
    end
  end

  assign rs1_pending = rs1_match_s && (rs1_addr != REG_X0);
  assign rs2_pending = rs2_match_s && (rs2_addr != REG_X0);
  assign pending_cnt = 4'(alu_cnt_s) + 4'(lsu_cnt_s);
endmodule
